rodata_load_unit: RTL and testbench
===================================

Name: rodata_load_unit

Overview:
Sequential load front-end for the read-only data memory. Accepts a RISC-V load request (address plus funct3) and drives the word-aligned address into the combinational ROM read port. It captures one ROM word, or two ROM words when the access crosses a word boundary. It returns a byte/half/word result, sign- or zero-extended, on a valid/ready response channel.

Parameters:
XLEN, 32, data/address width; must equal the ROM read-port width.
ALLOW_MISALIGNED, 1, 1 = split word-crossing accesses into two ROM reads; 0 = report them as faults.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous active-high reset
i_req_valid  in  1  load request valid
o_req_ready  out  1  unit can accept a request
i_req_addr  in  XLEN  byte address
i_req_funct3  in  3  000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
o_rom_addr  out  XLEN  word-aligned address to ROM read port
i_rom_rdata  in  XLEN  ROM word (combinational, little-endian byte lanes)
o_resp_valid  out  1  response valid
i_resp_ready  in  1  consumer accepts response
o_resp_data  out  XLEN  extended load result
o_resp_fault  out  1  illegal funct3 or disallowed misaligned access

Behaviour:
- Clocking: one clock i_clk. Reset i_rst is asynchronous and active-high.
- Reset values: state IDLE; o_resp_valid=0, o_resp_data=0, o_resp_fault=0, o_rom_addr=0; latched addr/funct3 = 0.
- FSM states: IDLE, READ0, READ1, RESP.
- o_req_ready = 1 only in IDLE. Request handshake = i_req_valid & o_req_ready.
- IDLE, on handshake:
  - latch addr and funct3;
  - illegal funct3 (011, 110, 111) -> RESP with fault=1, data=0;
  - word-crossing access with ALLOW_MISALIGNED=0 -> RESP with fault=1, data=0;
  - otherwise -> READ0.
- Word-crossing condition: addr[1:0] + size > 4, with size 1/2/4 bytes.
- READ0:
  - o_rom_addr = {addr[XLEN-1:2], 2'b00}; register i_rom_rdata as word0;
  - word-crossing -> READ1; otherwise compute result -> RESP.
- READ1:
  - o_rom_addr = word0 address + 4, modulo 2^XLEN, so 0xFFFFFFFC wraps to 0;
  - register i_rom_rdata as word1; compute result -> RESP.
- Result computation:
  - form {word1, word0} (word1 = 0 when unused) and shift right by addr[1:0]*8;
  - take the low 8/16/32 bits;
  - LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
- o_resp_data and o_resp_fault are registered on entry to RESP.
- RESP:
  - o_resp_valid=1; data and fault held stable until i_resp_ready;
  - on i_resp_ready -> IDLE; o_resp_valid drops the next cycle; data/fault keep last value.
- o_rom_addr in IDLE and RESP: holds last driven value.
- Latency, request handshake edge to o_resp_valid high:
  - aligned: 2 cycles;
  - word-crossing: 3 cycles;
  - fault: 1 cycle.
- Throughput: minimum 3 cycles per aligned request with i_resp_ready held high. No new request is accepted in the cycle a response completes.
- Reset asserted in any state, including mid READ1 or during a stalled RESP: immediately returns to IDLE with reset output values. The in-flight request is discarded and no response is produced.
- i_req_* is ignored when o_req_ready=0.

Test Plan:
- ROM setup for all tests: word 0x100 = 0xDDCCBBAA, word 0x104 = 0x44332211.
- LW 0x100 -> o_rom_addr=0x100; o_resp_data=0xDDCCBBAA, fault=0; valid 2 cycles after handshake.
- LB 0x103 -> 0xFFFFFFDD; LBU 0x103 -> 0x000000DD; LH 0x102 -> 0xFFFFDDCC; LHU 0x101 -> 0x0000CCBB.
- LW 0x102, ALLOW_MISALIGNED=1 -> o_rom_addr 0x100 then 0x104; data 0x2211DDCC; valid after 3 cycles. LH 0x103 -> 0x000011DD.
- Same LW 0x102 with ALLOW_MISALIGNED=0 -> fault=1, data=0, valid after 1 cycle. funct3=011 -> fault=1, data=0.
- i_resp_ready held low 4 cycles in RESP -> valid/data/fault stable; o_req_ready=0; a new i_req_valid is ignored. Release -> IDLE; next request accepted.
- Assert i_rst during READ1 of LW 0x102 -> asynchronously IDLE, o_resp_valid=0, o_resp_data=0. Following LW 0x104 -> 0x44332211.

Source files
------------

// File: rtl/rodata_load_unit.sv
// Sequential RISC-V load front-end for the read-only data ROM (byte/half/word, sign/zero extend).
// Latency handshake->resp_valid: 2 cycles aligned, 3 word-crossing (two ROM reads), 1 on fault.
// Backpressure: one request in flight; req_ready only in IDLE, response held until resp_ready.
module rodata_load_unit #(
   parameter int XLEN             = 32,
   parameter bit ALLOW_MISALIGNED = 1'b1
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [2:0]      i_req_funct3,
   output logic [XLEN-1:0] o_rom_addr,
   input  logic [XLEN-1:0] i_rom_rdata,
   output logic            o_resp_valid,
   input  logic            i_resp_ready,
   output logic [XLEN-1:0] o_resp_data,
   output logic            o_resp_fault
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      READ0 = 2'd1,
      READ1 = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state, state_nxt;
   logic [1:0]      offset_q;
   logic [2:0]      funct3_q;
   logic [XLEN-1:0] word0_q;
   logic [XLEN-1:0] rom_addr_q;
   logic [XLEN-1:0] resp_data_q;
   logic            resp_fault_q;

   logic              req_fire;
   logic              req_illegal;
   logic              req_fault;
   logic              lat_cross;
   logic [XLEN-1:0]   word0_src;
   logic [XLEN-1:0]   word1_src;
   logic [2*XLEN-1:0] shifted;
   logic [XLEN-1:0]   result;

   function automatic logic [2:0] size_of(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic crosses(input logic [1:0] off, input logic [1:0] sz);
      return ({1'b0, off} + size_of(sz)) > 3'd4;
   endfunction

   assign o_req_ready  = (state == IDLE);
   assign o_resp_valid = (state == RESP);
   assign o_rom_addr   = rom_addr_q;
   assign o_resp_data  = resp_data_q;
   assign o_resp_fault = resp_fault_q;

   assign req_fire    = i_req_valid & o_req_ready;
   assign req_illegal = (i_req_funct3 == 3'b011) || (i_req_funct3[2:1] == 2'b11);
   assign req_fault   = req_illegal ||
                        (!ALLOW_MISALIGNED && crosses(i_req_addr[1:0], i_req_funct3[1:0]));
   assign lat_cross   = crosses(offset_q, funct3_q[1:0]);

   // The ROM is combinational, so the word for the current read state is live on i_rom_rdata.
   always_comb begin
      word0_src = (state == READ0) ? i_rom_rdata : word0_q;
      word1_src = (state == READ1) ? i_rom_rdata : '0;
      shifted   = {word1_src, word0_src} >> {offset_q, 3'b000};
      case (funct3_q)
         3'b000:  result = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
         3'b001:  result = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
         3'b010:  result = shifted[XLEN-1:0];
         3'b100:  result = {{(XLEN-8){1'b0}}, shifted[7:0]};
         3'b101:  result = {{(XLEN-16){1'b0}}, shifted[15:0]};
         default: result = '0;
      endcase
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (req_fire) state_nxt = req_fault ? RESP : READ0;
         READ0:   state_nxt = lat_cross ? READ1 : RESP;
         READ1:   state_nxt = RESP;
         RESP:    if (i_resp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         offset_q     <= '0;
         funct3_q     <= '0;
         word0_q      <= '0;
         rom_addr_q   <= '0;
         resp_data_q  <= '0;
         resp_fault_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_fire) begin
                  offset_q <= i_req_addr[1:0];
                  funct3_q <= i_req_funct3;
                  if (req_fault) begin
                     resp_data_q  <= '0;
                     resp_fault_q <= 1'b1;
                  end else begin
                     rom_addr_q <= {i_req_addr[XLEN-1:2], 2'b00};
                  end
               end
            end
            READ0: begin
               word0_q <= i_rom_rdata;
               if (lat_cross) begin
                  rom_addr_q <= rom_addr_q + XLEN'(4);
               end else begin
                  resp_data_q  <= result;
                  resp_fault_q <= 1'b0;
               end
            end
            READ1: begin
               resp_data_q  <= result;
               resp_fault_q <= 1'b0;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_rodata_load_unit.sv
// Bench for rodata_load_unit: one instance allows misaligned loads, one faults them;
// directed cases plus random loads scored against a byte-level reference model.
module tb_rodata_load_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00;
   logic [1:0]  req_ready;
   logic [31:0] req_addr = '0;
   logic [2:0]  req_funct3 = '0;
   logic [31:0] rom_addr  [2];
   logic [31:0] rom_rdata [2];
   logic [1:0]  resp_valid;
   logic        resp_ready = 1'b0;
   logic [31:0] resp_data [2];
   logic [1:0]  resp_fault;

   int vectors = 0;
   int errors  = 0;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom_word(input logic [31:0] a);
      if (a == 32'h100) return 32'hDDCCBBAA;
      if (a == 32'h104) return 32'h44332211;
      return (a * 32'h9E3779B1) ^ 32'h5A5A5A5A;
   endfunction

   assign rom_rdata[0] = rom_word(rom_addr[0]);
   assign rom_rdata[1] = rom_word(rom_addr[1]);

   rodata_load_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b1)) dut_mis (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
      .i_req_addr(req_addr), .i_req_funct3(req_funct3),
      .o_rom_addr(rom_addr[0]), .i_rom_rdata(rom_rdata[0]),
      .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready),
      .o_resp_data(resp_data[0]), .o_resp_fault(resp_fault[0])
   );

   rodata_load_unit #(.XLEN(32), .ALLOW_MISALIGNED(1'b0)) dut_ali (
      .i_clk(clk), .i_rst(rst),
      .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
      .i_req_addr(req_addr), .i_req_funct3(req_funct3),
      .o_rom_addr(rom_addr[1]), .i_rom_rdata(rom_rdata[1]),
      .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready),
      .o_resp_data(resp_data[1]), .o_resp_fault(resp_fault[1])
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [7:0] byte_at(input logic [31:0] ba);
      logic [31:0] w;
      w = rom_word({ba[31:2], 2'b00});
      return w[8*ba[1:0] +: 8];
   endfunction

   // Reference: gather bytes one at a time from the byte-addressed ROM view.
   function automatic void model(input logic [31:0] a, input logic [2:0] f3, input bit allow,
                                 output logic [31:0] d, output logic f, output int lat);
      int n;
      logic [31:0] v;
      d = '0; f = 1'b0; v = '0; lat = 2;
      case (f3)
         3'b000, 3'b100: n = 1;
         3'b001, 3'b101: n = 2;
         3'b010:         n = 4;
         default:        n = 0;
      endcase
      if (n == 0) begin f = 1'b1; lat = 1; return; end
      if (int'(a[1:0]) + n > 4) begin
         if (!allow) begin f = 1'b1; lat = 1; return; end
         lat = 3;
      end
      for (int i = 0; i < n; i++) v = v | (32'(byte_at(a + 32'(i))) << (8 * i));
      case (f3)
         3'b000:  d = {{24{v[7]}}, v[7:0]};
         3'b001:  d = {{16{v[15]}}, v[15:0]};
         default: d = v;
      endcase
   endfunction

   // Entered and left at posedge+1 with the selected instance idle.
   task automatic do_load(input int u, input logic [31:0] a, input logic [2:0] f3, input int stall);
      logic [31:0] ed;
      logic        ef;
      int          el;
      int          k;
      bit          got;
      model(a, f3, (u == 0), ed, ef, el);
      check("req_ready_idle", 32'(req_ready[u]), 1);
      req_addr = a; req_funct3 = f3; req_valid[u] = 1'b1;
      k = 0; got = 1'b0;
      while (!got && k < 8) begin
         @(posedge clk); #1;
         k++;
         if (k == 1) req_valid[u] = 1'b0;
         if (!ef && k == 1) check("rom_addr_w0", rom_addr[u], {a[31:2], 2'b00});
         if (!ef && el == 3 && k == 2) check("rom_addr_w1", rom_addr[u], {a[31:2], 2'b00} + 32'd4);
         got = resp_valid[u];
      end
      check("latency", 32'(k), 32'(el));
      check("resp_data", resp_data[u], ed);
      check("resp_fault", 32'(resp_fault[u]), 32'(ef));
      for (int s = 0; s < stall; s++) begin
         if (s == 0) begin req_valid[u] = 1'b1; req_addr = a ^ 32'h8; end
         @(posedge clk); #1;
         check("stall_valid", 32'(resp_valid[u]), 1);
         check("stall_data", resp_data[u], ed);
         check("stall_fault", 32'(resp_fault[u]), 32'(ef));
         check("stall_req_ready", 32'(req_ready[u]), 0);
      end
      req_valid[u] = 1'b0; req_addr = a;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      check("valid_drop", 32'(resp_valid[u]), 0);
      check("ready_back", 32'(req_ready[u]), 1);
      check("data_kept", resp_data[u], ed);
   endtask

   initial begin
      logic [31:0] a;
      #2;
      for (int u = 0; u < 2; u++) begin
         check("rst_valid", 32'(resp_valid[u]), 0);
         check("rst_data", resp_data[u], 0);
         check("rst_fault", 32'(resp_fault[u]), 0);
         check("rst_rom_addr", rom_addr[u], 0);
         check("rst_req_ready", 32'(req_ready[u]), 1);
      end
      @(posedge clk); #3 rst = 1'b0;
      @(posedge clk); #1;

      do_load(0, 32'h100, 3'b010, 0);
      do_load(0, 32'h103, 3'b000, 0);
      do_load(0, 32'h103, 3'b100, 0);
      do_load(0, 32'h102, 3'b001, 0);
      do_load(0, 32'h101, 3'b101, 0);
      do_load(0, 32'h102, 3'b010, 0);
      do_load(0, 32'h103, 3'b001, 0);
      do_load(1, 32'h102, 3'b010, 0);
      do_load(1, 32'h104, 3'b010, 0);
      do_load(0, 32'h100, 3'b011, 0);
      do_load(0, 32'h100, 3'b010, 4);
      do_load(0, 32'hFFFFFFFE, 3'b010, 0);
      do_load(0, 32'h101, 3'b000, 0);

      // Reset while the second word of a crossing load is being fetched.
      req_addr = 32'h102; req_funct3 = 3'b010; req_valid[0] = 1'b1;
      @(posedge clk); #1 req_valid[0] = 1'b0;
      @(posedge clk); #1;
      check("pre_rst_rom_addr", rom_addr[0], 32'h104);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(resp_valid[0]), 0);
      check("mid_rst_data", resp_data[0], 0);
      check("mid_rst_rom_addr", rom_addr[0], 0);
      check("mid_rst_req_ready", 32'(req_ready[0]), 1);
      @(posedge clk); #1 rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("no_resp_after_rst", 32'(resp_valid[0]), 0);
      end
      do_load(0, 32'h104, 3'b010, 0);

      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0:       a = $urandom();
            1:       a = 32'hFFFFFFF8 + 32'($urandom_range(0, 7));
            default: a = 32'h100 + 32'($urandom_range(0, 7));
         endcase
         do_load(int'($urandom_range(0, 1)), a, 3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
